// File: rtl/gates7_pkg.sv
// Shared constants for the seven-function NAND-built logic cell.
//   IDX_*   : bit position of each function inside the packed function vector
//   N_FUNCS : number of functions (width of the packed vector)
//   func_vec_t : packed vector type {xnor,xor,nor,nand,not,or,and}
package gates7_pkg;

  localparam int unsigned IDX_AND  = 0;
  localparam int unsigned IDX_OR   = 1;
  localparam int unsigned IDX_NOT  = 2;
  localparam int unsigned IDX_NAND = 3;
  localparam int unsigned IDX_NOR  = 4;
  localparam int unsigned IDX_XOR  = 5;
  localparam int unsigned IDX_XNOR = 6;

  localparam int unsigned N_FUNCS  = 7;

  typedef logic [N_FUNCS-1:0] func_vec_t;

endpackage

// File: rtl/gates7_nand2.sv
// Two-input NAND leaf cell; the only primitive the gates7 netlist is built from.
// Ports:
//   a, b : inputs
//   y    : ~(a & b)
module gates7_nand2 (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = ~(a & b);

endmodule

// File: rtl/gates7_structural.sv
// Seven-function 2-input logic cell (AND, OR, NOT a, NAND, NOR, XOR, XNOR)
// composed purely from gates7_nand2 instances.
// Configuration macro: GATES7_REG_OUT_EN adds a registered copy f_vec_q.
// Ports:
//   clk, rst_n : clock and async active-low reset (registered stage only)
//   a, b       : operands
//   f_and .. f_xnor : combinational function outputs, valid during reset
//   f_vec_q    : (GATES7_REG_OUT_EN only) registered {xnor,xor,nor,nand,not,or,and}
module gates7_structural
  import gates7_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  output logic f_and,
  output logic f_or,
  output logic f_not,
  output logic f_nand,
  output logic f_nor,
  output logic f_xor,
  output logic f_xnor
`ifdef GATES7_REG_OUT_EN
  ,
  output func_vec_t f_vec_q
`endif
);

  logic not_a;
  logic not_b;
  logic nand_ab;
  logic and_ab;
  logic or_ab;
  logic nor_ab;
  logic xor_l;
  logic xor_r;
  logic xor_ab;
  logic xnor_ab;

  // Inverters: a NAND with both inputs tied together
  gates7_nand2 u_not_a (.a(a), .b(a), .y(not_a));
  gates7_nand2 u_not_b (.a(b), .b(b), .y(not_b));

  gates7_nand2 u_nand  (.a(a),       .b(b),       .y(nand_ab));
  gates7_nand2 u_and   (.a(nand_ab), .b(nand_ab), .y(and_ab));

  // De Morgan: a | b == ~(~a & ~b)
  gates7_nand2 u_or    (.a(not_a),   .b(not_b),   .y(or_ab));
  gates7_nand2 u_nor   (.a(or_ab),   .b(or_ab),   .y(nor_ab));

  // Classic 4-NAND XOR, sharing the first NAND with the f_nand output
  gates7_nand2 u_xor_l (.a(a),       .b(nand_ab), .y(xor_l));
  gates7_nand2 u_xor_r (.a(b),       .b(nand_ab), .y(xor_r));
  gates7_nand2 u_xor   (.a(xor_l),   .b(xor_r),   .y(xor_ab));
  gates7_nand2 u_xnor  (.a(xor_ab),  .b(xor_ab),  .y(xnor_ab));

  assign f_and  = and_ab;
  assign f_or   = or_ab;
  assign f_not  = not_a;
  assign f_nand = nand_ab;
  assign f_nor  = nor_ab;
  assign f_xor  = xor_ab;
  assign f_xnor = xnor_ab;

`ifdef GATES7_REG_OUT_EN
  func_vec_t f_vec;

  always_comb begin
    f_vec           = '0;
    f_vec[IDX_AND]  = and_ab;
    f_vec[IDX_OR]   = or_ab;
    f_vec[IDX_NOT]  = not_a;
    f_vec[IDX_NAND] = nand_ab;
    f_vec[IDX_NOR]  = nor_ab;
    f_vec[IDX_XOR]  = xor_ab;
    f_vec[IDX_XNOR] = xnor_ab;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_vec_q <= '0;
    end else begin
      f_vec_q <= f_vec;
    end
  end
`else
  // Clock and reset are kept as ports for drop-in compatibility but unused here
  logic unused_clk_rst;
  assign unused_clk_rst = &{1'b0, clk, rst_n};
`endif

endmodule

// File: tb/tb_gates7_structural.sv
// Randomized and directed checks of gates7_structural against a reference
// model that derives each function from the count of ones on a and b.
module tb_gates7_structural;

  logic clk;
  logic rst_n;
  logic a;
  logic b;
  logic f_and, f_or, f_not, f_nand, f_nor, f_xor, f_xnor;
`ifdef GATES7_REG_OUT_EN
  logic [6:0] f_vec_q;
`endif

  int unsigned tests;
  int unsigned fails;

  gates7_structural dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .f_and  (f_and),
    .f_or   (f_or),
    .f_not  (f_not),
    .f_nand (f_nand),
    .f_nor  (f_nor),
    .f_xor  (f_xor),
    .f_xnor (f_xnor)
`ifdef GATES7_REG_OUT_EN
    ,
    .f_vec_q(f_vec_q)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: classify inputs by how many are 1, bit order {xnor,xor,nor,nand,not,or,and}
  function automatic logic [6:0] ref_vec(input bit ra, input bit rb);
    int ones;
    logic [6:0] v;
    ones = int'(ra) + int'(rb);
    v[0] = (ones == 2);
    v[1] = (ones >= 1);
    v[2] = (ra == 1'b0);
    v[3] = (ones != 2);
    v[4] = (ones == 0);
    v[5] = (ones == 1);
    v[6] = (ones != 1);
    return v;
  endfunction

  function automatic logic [6:0] dut_vec();
    return {f_xnor, f_xor, f_nor, f_nand, f_not, f_or, f_and};
  endfunction

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic apply(input bit na, input bit nb);
    a = na;
    b = nb;
    #1;
  endtask

  logic [1:0]  dir_in  [4];
  logic [6:0]  dir_exp [4];

  initial begin
    tests = 0;
    fails = 0;
    a = 1'b0;
    b = 1'b0;
    rst_n = 1'b0;

    // Truth-table constants indexed in the order 00, 10, 01, 11 (a,b)
    dir_in[0] = 2'b00; dir_exp[0] = 7'b1011100;
    dir_in[1] = 2'b10; dir_exp[1] = 7'b0101010;
    dir_in[2] = 2'b01; dir_exp[2] = 7'b0101110;
    dir_in[3] = 2'b11; dir_exp[3] = 7'b1000011;

    // Combinational outputs must follow the table while reset is held
    #2;
    for (int i = 0; i < 4; i++) begin
      apply(dir_in[i][1], dir_in[i][0]);
      check("in_reset", dut_vec(), dir_exp[i]);
    end
`ifdef GATES7_REG_OUT_EN
    check("vec_q_reset", f_vec_q, 7'h00);
`endif

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      apply(dir_in[i][1], dir_in[i][0]);
      check("directed", dut_vec(), dir_exp[i]);
    end

    // Randomized sweep with complementary-pair invariants
    for (int i = 0; i < 40; i++) begin
      bit ra, rb;
      logic [6:0] v;
      ra = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      apply(ra, rb);
      v = dut_vec();
      check("random", v, ref_vec(ra, rb));
      check("inv_pairs", {5'b0, f_nand, f_nor, f_xnor}, {5'b0, ~f_and, ~f_or, ~f_xor});
    end

`ifdef GATES7_REG_OUT_EN
    // Registered copy: async clear, then 1-cycle load of the inputs before each edge
    @(negedge clk);
    a = 1'b1;
    b = 1'b1;
    rst_n = 1'b0;
    #1;
    check("vec_q_async_clr", f_vec_q, 7'h00);
    @(negedge clk);
    rst_n = 1'b1;
    a = 1'b1;
    b = 1'b1;
    @(posedge clk);
    #1;
    check("vec_q_first_load", f_vec_q, 7'b1000011);
    for (int i = 0; i < 20; i++) begin
      bit ra, rb;
      @(negedge clk);
      ra = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      a = ra;
      b = rb;
      @(posedge clk);
      #1;
      check("vec_q_random", f_vec_q, ref_vec(ra, rb));
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
